// File: rtl/aes_uart_pkg.sv
// aes_uart_pkg: shared types and constants
// for the AES block to UART byte sender.
package aes_uart_pkg;

  localparam int BLK_W = 128;

  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_LF         = 8'h0A;
  localparam logic [7:0] ASCII_0          = 8'h30;
  localparam logic [7:0] ASCII_A_MINUS_10 = 8'h37;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/aes_uart_block_sender_nib.sv
// nibble_to_ascii: 4-bit value to uppercase
// ASCII hex digit.
import aes_uart_pkg::*;

module nibble_to_ascii (
  input  logic [3:0] nib,
  output logic [7:0] chr
);

  // digits map from '0', letters from 'A'
  always_comb begin
    chr = ASCII_0 + {4'h0, nib};
    if (nib > 4'd9)
      chr = ASCII_A_MINUS_10 + {4'h0, nib};
  end

endmodule

// File: rtl/aes_uart_block_sender.sv
// aes_uart_block_sender: serializes one AES
// block as raw bytes or hex text to a UART.
import aes_uart_pkg::*;

module aes_uart_block_sender #(
  parameter bit HEX_MODE    = 1'b1,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_valid,
  input  logic [BLK_W-1:0] blk_data,
  output logic             blk_ready,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic             done,
  output logic             active
);

  localparam logic [5:0] LAST =
    HEX_MODE ? (APPEND_CRLF ? 6'd33 : 6'd31)
             : 6'd15;

  state_t           state, state_d;
  logic [5:0]       k, k_d;
  logic [BLK_W-1:0] blk_copy;
  logic             cap;
  logic [7:0]       tx_data_d;
  logic             tx_start_d;
  logic             done_d;
  logic             active_d;
  logic             ready_d;
  logic [3:0]       nib;
  logic [7:0]       hex_chr;
  logic [7:0]       raw_byte;
  logic [7:0]       chr;

  // select the nibble / byte for character k
  always_comb begin
    nib      = blk_copy[BLK_W-1-4*int'(k[4:0]) -: 4];
    raw_byte = blk_copy[BLK_W-1-8*int'(k[3:0]) -: 8];
  end

  nibble_to_ascii u_hex (
    .nib (nib),
    .chr (hex_chr)
  );

  // character k: hex digit, CR/LF trailer or raw byte
  always_comb begin
    chr = raw_byte;
    if (HEX_MODE) begin
      unique case (1'b1)
        (k == 6'd32): chr = ASCII_CR;
        (k == 6'd33): chr = ASCII_LF;
        default:      chr = hex_chr;
      endcase
    end
  end

  // next state and registered-output values
  always_comb begin
    state_d    = state;
    k_d        = k;
    cap        = 1'b0;
    tx_data_d  = tx_data;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    active_d   = active;
    ready_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (blk_ready && blk_valid) begin
          cap      = 1'b1;
          k_d      = 6'd0;
          active_d = 1'b1;
          state_d  = LOAD;
        end else begin
          ready_d  = 1'b1;
        end
      end
      LOAD: begin
        // never start while a stale frame runs
        if (!tx_busy) begin
          tx_data_d  = chr;
          tx_start_d = 1'b1;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // busy lags start; only a high is meaningful
        if (tx_busy)
          state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (k == LAST) begin
            done_d   = 1'b1;
            active_d = 1'b0;
            ready_d  = 1'b1;
            state_d  = IDLE;
          end else begin
            k_d     = k + 6'd1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= 6'd0;
      tx_data   <= 8'h00;
      tx_start  <= 1'b0;
      done      <= 1'b0;
      active    <= 1'b0;
      blk_ready <= 1'b0;
    end else begin
      state     <= state_d;
      k         <= k_d;
      tx_data   <= tx_data_d;
      tx_start  <= tx_start_d;
      done      <= done_d;
      active    <= active_d;
      blk_ready <= ready_d;
    end
  end

  // private copy of the accepted block
  always_ff @(posedge clk) begin
    if (cap)
      blk_copy <= blk_data;
  end

endmodule

// File: tb/tb_aes_uart_block_sender.sv
// tb_aes_uart_block_sender: hex and raw lanes,
// each with a UART model and line decoder.
module tb_aes_uart_block_sender;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         blk_valid [2];
  logic [127:0] blk_data  [2];
  logic         blk_ready [2];
  logic         tx_start  [2];
  logic [7:0]   tx_data   [2];
  logic         tx_busy   [2];
  logic         done      [2];
  logic         active    [2];
  logic         rx_valid  [2];
  logic [7:0]   rx_byte   [2];
  logic         rx_stop   [2];

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  int total = 0;
  int passed = 0;
  int starts_blk [2] = '{0, 0};
  int starts_tot [2] = '{0, 0};
  int done_cnt   [2] = '{0, 0};
  int exp_done   [2] = '{0, 0};
  bit armed      [2] = '{0, 0};
  logic [7:0] held [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic       u_busy;
    logic       txd;
    logic [9:0] u_sh;
    logic [3:0] u_bit;
    logic [1:0] u_cnt;
    logic       d_act;
    logic [5:0] d_cnt;
    logic [7:0] d_sh;
    logic       rv;
    logic [7:0] rb;
    logic       rs;

    aes_uart_block_sender #(
      .HEX_MODE    (g == 0),
      .APPEND_CRLF (1'b1)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .blk_valid (blk_valid[g]),
      .blk_data  (blk_data[g]),
      .blk_ready (blk_ready[g]),
      .tx_start  (tx_start[g]),
      .tx_data   (tx_data[g]),
      .tx_busy   (tx_busy[g]),
      .done      (done[g]),
      .active    (active[g])
    );

    // UART transmitter, 4 clocks per bit, 8N1
    always @(posedge clk) begin
      if (rst) begin
        u_busy <= 1'b0;
        txd    <= 1'b1;
      end else if (!u_busy) begin
        if (tx_start[g]) begin
          u_busy <= 1'b1;
          u_sh   <= {1'b1, tx_data[g], 1'b0};
          u_bit  <= 4'd0;
          u_cnt  <= 2'd0;
          txd    <= 1'b0;
        end
      end else if (u_cnt == 2'd3) begin
        u_cnt <= 2'd0;
        if (u_bit == 4'd9) begin
          u_busy <= 1'b0;
          txd    <= 1'b1;
        end else begin
          u_bit <= u_bit + 4'd1;
          txd   <= u_sh[u_bit + 4'd1];
        end
      end else begin
        u_cnt <= u_cnt + 2'd1;
      end
    end

    // serial-line decoder, samples mid-bit
    always @(posedge clk) begin
      rv <= 1'b0;
      if (rst) begin
        d_act <= 1'b0;
      end else if (!d_act) begin
        if (!txd) begin
          d_act <= 1'b1;
          d_cnt <= 6'd1;
        end
      end else begin
        d_cnt <= d_cnt + 6'd1;
        if (d_cnt >= 6'd5 && d_cnt <= 6'd33 && d_cnt[1:0] == 2'd1)
          d_sh <= {txd, d_sh[7:1]};
        if (d_cnt == 6'd37) begin
          d_act <= 1'b0;
          rv    <= 1'b1;
          rb    <= d_sh;
          rs    <= txd;
        end
      end
    end

    assign tx_busy[g]  = u_busy;
    assign rx_valid[g] = rv;
    assign rx_byte[g]  = rb;
    assign rx_stop[g]  = rs;
  end

  task automatic chk(string name, int g,
                     logic [127:0] got, logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s[%0d]: got %0h expected %0h",
                  name, g, got, exp);
  endtask

  task automatic fail(string name, int g);
    total++;
    $display("FAIL %s[%0d]: timed out", name, g);
  endtask

  function automatic int nchars(int g);
    return (g == 0) ? 34 : 16;
  endfunction

  function automatic int qsize(int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] qpop(int g);
    return (g == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic void qclear(int g);
    if (g == 0) q0.delete();
    else q1.delete();
  endfunction

  // reference: the text a terminal should show
  function automatic void push_exp(int g, logic [127:0] b);
    string hexd = "0123456789ABCDEF";
    logic [127:0] t;
    if (g == 0) begin
      for (int i = 0; i < 32; i++) begin
        t = b >> (124 - 4 * i);
        q0.push_back(hexd[t[3:0]]);
      end
      q0.push_back(8'h0D);
      q0.push_back(8'h0A);
    end else begin
      for (int i = 0; i < 16; i++) begin
        t = b >> (120 - 8 * i);
        q1.push_back(t[7:0]);
      end
    end
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // monitor: decoded chars and handshake rules
  initial forever begin
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      if (rx_valid[g] === 1'b1) begin
        if (qsize(g) == 0) begin
          total++;
          $display("FAIL unexpected_char[%0d]: got %02h expected none",
                   g, rx_byte[g]);
        end else begin
          chk("char", g, rx_byte[g], qpop(g));
        end
        chk("stop_bit", g, rx_stop[g], 1);
      end
      if (tx_start[g] === 1'b1) begin
        chk("start_while_busy", g, tx_busy[g], 0);
        starts_blk[g]++;
        starts_tot[g]++;
        held[g]  = tx_data[g];
        armed[g] = 1'b1;
      end else if (armed[g]) begin
        chk("tx_data_stable", g, tx_data[g], held[g]);
      end
      if (tx_start[g] === 1'b1 || tx_busy[g] === 1'b1)
        chk("active_during_tx", g, active[g], 1);
      if (active[g] === 1'b1)
        chk("ready_low_active", g, blk_ready[g], 0);
      if (done[g] === 1'b1) begin
        done_cnt[g]++;
        chk("starts_per_block", g, starts_blk[g], nchars(g));
        chk("chars_before_done", g, qsize(g), 0);
        starts_blk[g] = 0;
      end
      if (rst) begin
        qclear(g);
        starts_blk[g] = 0;
        armed[g] = 1'b0;
      end
    end
  end

  task automatic send(int g, logic [127:0] b, bit complete);
    int n = 0;
    blk_valid[g] = 1'b1;
    blk_data[g]  = b;
    while (!blk_ready[g] && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!blk_ready[g]) begin
      fail("accept", g);
      blk_valid[g] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    blk_valid[g] = 1'b0;
    blk_data[g]  = rnd128();
    push_exp(g, b);
    if (complete) exp_done[g]++;
  endtask

  // offer a foreign block mid-transfer
  task automatic poke(int g, logic [127:0] b);
    int n = 0;
    while (starts_blk[g] < 5 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (starts_blk[g] < 5) fail("poke_wait", g);
    blk_valid[g] = 1'b1;
    blk_data[g]  = ~b;
    @(posedge clk); #1;
    blk_valid[g] = 1'b0;
  endtask

  task automatic wait_done(int g);
    int n = 0;
    while (done_cnt[g] != exp_done[g] && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_count", g, done_cnt[g], exp_done[g]);
  endtask

  task automatic directed(int g);
    logic [127:0] b;
    b = (g == 0) ? 128'h00112233445566778899AABBCCDDEEFF
                 : 128'h0123456789ABCDEFFEDCBA9876543210;
    send(g, b, 1'b1);
    poke(g, b);
    wait_done(g);
  endtask

  task automatic back2back(int g);
    send(g, rnd128(), 1'b1);
    send(g, rnd128(), 1'b1);
    send(g, rnd128(), 1'b1);
    wait_done(g);
  endtask

  task automatic chk_reset_vals(bit rdy);
    for (int g = 0; g < 2; g++) begin
      chk("rst_blk_ready", g, blk_ready[g], rdy);
      chk("rst_tx_start", g, tx_start[g], 0);
      chk("rst_tx_data", g, tx_data[g], 0);
      chk("rst_done", g, done[g], 0);
      chk("rst_active", g, active[g], 0);
    end
  endtask

  initial begin
    int n;
    int s0;
    int s1;
    for (int g = 0; g < 2; g++) begin
      blk_valid[g] = 1'b0;
      blk_data[g]  = '0;
    end
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk_reset_vals(1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals(1'b1);

    fork
      directed(0);
      directed(1);
    join

    fork
      back2back(0);
      back2back(1);
    join

    fork
      send(0, rnd128(), 1'b0);
      send(1, rnd128(), 1'b0);
    join
    n = 0;
    while (starts_blk[0] < 10 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (starts_blk[0] < 10) fail("char10_wait", 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals(1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals(1'b1);
    s0 = starts_tot[0];
    s1 = starts_tot[1];
    repeat (100) begin @(posedge clk); #1; end
    chk("no_start_after_rst", 0, starts_tot[0], s0);
    chk("no_start_after_rst", 1, starts_tot[1], s1);

    fork
      begin send(0, rnd128(), 1'b1); wait_done(0); end
      begin send(1, rnd128(), 1'b1); wait_done(1); end
    join

    repeat (20) begin @(posedge clk); #1; end
    for (int g = 0; g < 2; g++) begin
      chk("queue_empty", g, qsize(g), 0);
      chk("final_done", g, done_cnt[g], exp_done[g]);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog[0]: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_uart_block_sender.md
Name: aes_uart_block_sender

Overview:
- Upstream feeder for the byte-level UART transmitter.
- Takes one 128-bit AES result block through a valid/ready handshake and serializes it MSB byte first into the transmitter's tx_start/data/busy interface.
- Sends either raw bytes or uppercase ASCII hex followed by CR LF, so the block can be read on a terminal.
- Sits between the AES core output register and the UART transmitter.

Parameters:
- HEX_MODE, 1, 1 = 32 ASCII hex chars per block; 0 = 16 raw bytes.
- APPEND_CRLF, 1, when HEX_MODE=1, append 0x0D then 0x0A after the hex chars; ignored when HEX_MODE=0.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- blk_valid  in  1  block on blk_data is valid
- blk_data  in  128  AES block; bits [127:120] are sent first
- blk_ready  out  1  high when the block can be accepted (IDLE only)
- tx_start  out  1  one-cycle pulse that requests transmission of tx_data
- tx_data  out  8  byte to transmit; held stable from tx_start until the transmitter acknowledges
- tx_busy  in  1  transmitter busy flag; rises one cycle after it samples tx_start
- done  out  1  one-cycle pulse after the last character of a block has completed
- active  out  1  high from block accept until done

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values: blk_ready=0 in the cycle of reset, 1 in the first cycle after it; tx_start=0, tx_data=0x00, done=0, active=0; state=IDLE; char counter=0. Reset mid-transfer abandons the block immediately and emits no further tx_start.
- Character count N: HEX_MODE=1 gives 32, plus 2 if APPEND_CRLF. HEX_MODE=0 gives 16. Counter is 6 bits; index k runs 0..N-1.
- Character k in hex mode: for k<32, nibble = blk_copy[127-4k -: 4]. Nibbles 0..9 map to 0x30..0x39, and A..F map to 0x41..0x46 (uppercase). k=32 is 0x0D; k=33 is 0x0A.
- Character k in raw mode: blk_copy[127-8k -: 8].
- State machine:
  - IDLE: blk_ready=1. When blk_valid=1, capture blk_data into blk_copy, set k=0, active=1, blk_ready=0, go to LOAD.
  - LOAD: drive tx_data=char(k) and pulse tx_start=1 for exactly one cycle, then go to WAIT_ACK.
  - WAIT_ACK: tx_start=0. Wait for tx_busy=1, then go to WAIT_DONE. Because the transmitter's busy flag lags tx_start by one cycle, tx_busy must never be sampled low and treated as completion in this state.
  - WAIT_DONE: wait for tx_busy=0. If k==N-1: pulse done, set active=0, go to IDLE. Otherwise increment k and go to LOAD.
- At most one tx_start pulse is outstanding; no tx_start is issued while tx_busy=1.
- blk_valid asserted while not IDLE is ignored and is not queued. Upstream must hold blk_valid until it sees blk_ready high in the same cycle.
- A new block can be accepted in the cycle after done. Back-to-back blocks are supported with no lost or duplicated characters.
- tx_data changes only in LOAD; it stays constant through WAIT_ACK and WAIT_DONE.
- blk_copy is immune to blk_data changes after accept.

Decomposition:
- Shared package aes_uart_pkg holds: state encoding (IDLE, LOAD, WAIT_ACK, WAIT_DONE); constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_0=8'h30, ASCII_A_MINUS_10=8'h37; and the block width 128.
- One sub-module: nibble_to_ascii, a purely combinational 4-bit to 8-bit mapping, instantiated once on the nibble-select mux output.

Test Plan:
- Bench instantiates the real UART transmitter with CLKS_PER_BIT=4 and a serial-line decoder.
- Hex mode: blk_data=128'h00112233445566778899AABBCCDDEEFF -> decoder sees "00112233445566778899AABBCCDDEEFF" then 0x0D, 0x0A (34 chars); exactly one done pulse; active high throughout.
- Raw mode (HEX_MODE=0): blk_data=128'h0123456789ABCDEFFEDCBA9876543210 -> 16 bytes 0x01,0x23,…,0x10 in order; done fires after the 16th stop bit.
- Handshake: count tx_start pulses = N per block. Assert that tx_start is never high while tx_busy=1, and that tx_data is stable between each tx_start and the next LOAD.
- Back-to-back: hold blk_valid high with block A then block B (B applied the cycle after done) -> 68 correct chars; blk_ready is low throughout A; B is accepted on its first IDLE cycle.
- Ignore while busy: pulse blk_valid with a different value at char 5 of block A -> output is unchanged and the extra block is dropped.
- Reset mid-transfer: assert rst for 1 cycle at char 10 -> no further tx_start; the cycle after rst deasserts, outputs are at reset values with blk_ready=1; a new block is then sent completely and correctly.
